mac_col_mk: RTL
===============

Name: mac_col_mk

Overview:
- Parametrised successor to the single-key MAC column: one column of the Q·K array.
- Holds kdepth selectable key vectors and computes signed pr-lane dot products against the streamed q vector.
- Supports accumulate-across-executes and a fixed 2-stage pipeline.
- Columns daisy-chain: q, instruction and slot pass to the next column one cycle later. Results go to the per-column output FIFO via fifo_wr.

Parameters:
bw, 8, bits per q/key element (signed two's complement)
bw_psum, 32, psum/output width; must be >= 2*bw + clog2(pr)
pr, 8, lanes per vector
col_id, 0, column index; selects the load-counter value at which this column captures a key
kdepth, 4, key slots per column (power of 2, >= 2)
num_col, 8, columns in the chain; load counter saturates here

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
q_in  in  pr*bw  q/key vector; lane k = q_in[bw*k +: bw]
i_inst  in  3  [0]=load, [1]=execute, [2]=accumulate (meaningful only with execute)
i_slot  in  clog2(kdepth)  key slot for load or execute
q_out  out  pr*bw  q_in delayed 1 cycle
o_inst  out  3  i_inst delayed 1 cycle
o_slot  out  clog2(kdepth)  i_slot delayed 1 cycle
out  out  bw_psum  dot-product result (signed)
fifo_wr  out  1  one-cycle strobe, out valid

Behaviour:
- Reset (reset=0, asynchronous) clears the following to 0:
  - q_out, o_inst, o_slot, out, fifo_wr
  - all key slots, load counter, pipeline valids, products
- Reset mid-operation discards in-flight results. No fifo_wr may follow release of reset unless a new execute arrives.
- Pass-through: q_out/o_inst/o_slot register inputs every cycle, unconditionally.
- Load counter cnt (width clog2(num_col+1)):
  - When i_inst[0]=1 and cnt==col_id, capture q_in into key[i_slot].
  - While load is held, cnt increments each cycle, saturating at num_col.
  - cnt clears to 0 on any cycle with i_inst[0]=0.
  - Result: with inst and q skewed one cycle per column, each column captures a distinct vector from one load burst.
- Execute, stage 1 (edge after input cycle N where i_inst[1]=1):
  - Register pr signed products q_lane*key[i_slot]_lane, each 2*bw bits.
  - Register acc bit; set v1.
- Execute, stage 2 (edge N+2):
  - Sign-extend products and sum to bw_psum.
  - If acc=1: out <= out + sum. Else: out <= sum.
  - fifo_wr=1 for exactly that cycle.
- Latency: execute presented in cycle N gives out/fifo_wr valid in cycle N+2. Back-to-back executes give one result per cycle.
- Accumulate chaining:
  - Uses the out value registered at the time stage 2 fires, including a result completing in that same edge (forwarded).
  - Acc on the first execute after reset adds to 0.
- Arithmetic wraps modulo 2^bw_psum; no saturation.
- out holds its last value when fifo_wr=0.
- Load and execute in the same cycle on the same slot: execute uses the old key (read-before-write). Load still captures.
- Execute with load deasserted does not disturb cnt other than clearing it.
- i_inst[2]=1 without i_inst[1]: no effect.

Test Plan:
1. Load + execute, 2 chained columns: hold load 2 cycles on slot 0, keys {1,2,3,4,5,6,7,8} then {1,3,5,7,9,11,13,15} (lane 7 first). Then execute with q={1..8} -> col0 out=204 with fifo_wr at N+2; col1 out=372 at N+3.
2. Signed: col0 key {1..8}, execute q all 8'hFF -> out=32'hFFFFFFDC (-36), single fifo_wr pulse.
3. Multi-slot: load slot1 of col0 with all 8'd2, slot0 with {1..8}. Execute slot0 then slot1 with q={1..8}, back-to-back -> out=204 then 72 on consecutive cycles, fifo_wr high 2 cycles.
4. Accumulate: three back-to-back executes, q={1..8}, slot0, acc=0,1,1 -> out=204, 408, 612 (forwarding exercised).
5. Simultaneous load/execute on slot0 with new q={2..9} -> result uses old key {1..8}: out=1*2+...+8*9=240. A following execute with q all 1 -> 44 (new key sum).
6. Async reset: assert reset low one cycle after an execute -> fifo_wr and out go 0 immediately. After release, no fifo_wr pulse; key slots read as 0 (execute -> out=0).

Source files
------------

// File: rtl/mac_col_mk.sv
// -----------------------------------------------------------------------------
// mac_col_mk
//
// One column of the Q*K systolic array. The column keeps kdepth key vectors and
// computes a signed pr-lane dot product between the streamed q vector and the
// key selected by i_slot. Results can accumulate across executes. The column
// forwards q, the instruction and the slot to the next column one cycle later,
// so that a row of columns sees one wavefront skewed by one cycle per column.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   q_in     q / key vector, lane k = q_in[bw*k +: bw] (signed)
//   i_inst   [0]=load, [1]=execute, [2]=accumulate (only with execute)
//   i_slot   key slot addressed by load or execute
//   q_out    q_in delayed one cycle (to the next column)
//   o_inst   i_inst delayed one cycle
//   o_slot   i_slot delayed one cycle
//   out      signed dot-product result, holds between results
//   fifo_wr  one-cycle strobe marking a new value on out
//
// Timing: an execute presented in cycle N produces out/fifo_wr in cycle N+2.
//   stage 1 : per-lane products and the accumulate flag are registered
//   stage 2 : products are sign-extended, summed and written to out
// -----------------------------------------------------------------------------
module mac_col_mk #(
    parameter int bw      = 8,
    parameter int bw_psum = 32,
    parameter int pr      = 8,
    parameter int col_id  = 0,
    parameter int kdepth  = 4,
    parameter int num_col = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [pr*bw-1:0]           q_in,
    input  logic [2:0]                 i_inst,
    input  logic [$clog2(kdepth)-1:0]  i_slot,
    output logic [pr*bw-1:0]           q_out,
    output logic [2:0]                 o_inst,
    output logic [$clog2(kdepth)-1:0]  o_slot,
    output logic [bw_psum-1:0]         out,
    output logic                       fifo_wr
);

    localparam int cnt_w = $clog2(num_col + 1);

    // Width-matched copies of the integer parameters used in comparisons.
    localparam logic [cnt_w-1:0] col_id_c  = cnt_w'(col_id);
    localparam logic [cnt_w-1:0] num_col_c = cnt_w'(num_col);

    logic                     load;
    logic                     exec;

    // Key storage. Every slot must read as zero after reset, so the keys live
    // in resettable registers rather than a RAM.
    logic [pr*bw-1:0]         key_reg [kdepth];
    logic [pr*bw-1:0]         key_sel;
    logic [cnt_w-1:0]         cnt_reg;

    // Stage 1 state.
    logic                     v1_reg;
    logic                     acc1_reg;
    logic [pr-1:0][2*bw-1:0]  prod_next;
    logic [pr-1:0][2*bw-1:0]  prod_reg;

    // Stage 2 state and combinational sum.
    logic [pr-1:0][bw_psum-1:0] ext;
    logic [bw_psum-1:0]       sum_next;
    logic [bw_psum-1:0]       out_next;
    logic [bw_psum-1:0]       out_reg;
    logic                     wr_reg;

    assign load = i_inst[0];
    assign exec = i_inst[1];

    // -------------------------------------------------------------------------
    // Pass-through to the next column, registered every cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_out  <= '0;
            o_inst <= '0;
            o_slot <= '0;
        end else begin
            q_out  <= q_in;
            o_inst <= i_inst;
            o_slot <= i_slot;
        end
    end

    // -------------------------------------------------------------------------
    // Load counter and key capture.
    // During a held load burst the counter counts cycles since the burst
    // reached this column; because the burst arrives one cycle later at each
    // successive column, comparing against col_id makes every column grab a
    // different vector of the same burst. The counter saturates so that long
    // bursts cannot wrap round and re-trigger a capture.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
            for (int k = 0; k < kdepth; k++) begin
                key_reg[k] <= '0;
            end
        end else begin
            if (load) begin
                if (cnt_reg == col_id_c) begin
                    key_reg[i_slot] <= q_in;
                end
                if (cnt_reg != num_col_c) begin
                    cnt_reg <= cnt_reg + cnt_w'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    // Execute reads the key as it stood before this edge, so a load to the
    // same slot in the same cycle is seen only by later executes.
    assign key_sel = key_reg[i_slot];

    // -------------------------------------------------------------------------
    // Per-lane signed products. Both operands are sign-extended to 2*bw so the
    // low 2*bw bits of the multiply are the exact signed product.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < pr; gi++) begin : g_lane
        logic [bw-1:0]   q_lane;
        logic [bw-1:0]   k_lane;
        logic [2*bw-1:0] q_ext;
        logic [2*bw-1:0] k_ext;

        assign q_lane = q_in[bw*gi +: bw];
        assign k_lane = key_sel[bw*gi +: bw];
        assign q_ext  = {{bw{q_lane[bw-1]}}, q_lane};
        assign k_ext  = {{bw{k_lane[bw-1]}}, k_lane};
        assign prod_next[gi] = q_ext * k_ext;

        // Sign extension of the registered product to the psum width.
        assign ext[gi] = {{(bw_psum-2*bw){prod_reg[gi][2*bw-1]}}, prod_reg[gi]};
    end

    // -------------------------------------------------------------------------
    // Stage 1: capture products and the accumulate flag of an execute.
    // Products only change on an execute so idle cycles do not toggle them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_reg   <= 1'b0;
            acc1_reg <= 1'b0;
            prod_reg <= '0;
        end else begin
            v1_reg <= exec;
            if (exec) begin
                acc1_reg <= i_inst[2];
                prod_reg <= prod_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: reduce and optionally accumulate. out_reg already holds the
    // result of the previous edge, so back-to-back accumulates chain without a
    // separate bypass path. Arithmetic wraps at bw_psum bits.
    // -------------------------------------------------------------------------
    always_comb begin
        sum_next = '0;
        for (int k = 0; k < pr; k++) begin
            sum_next = sum_next + ext[k];
        end
    end

    assign out_next = acc1_reg ? (out_reg + sum_next) : sum_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_reg <= '0;
            wr_reg  <= 1'b0;
        end else begin
            wr_reg <= v1_reg;
            if (v1_reg) begin
                out_reg <= out_next;
            end
        end
    end

    assign out     = out_reg;
    assign fifo_wr = wr_reg;

endmodule
